// File: rtl/morph_frame_sequencer.sv
// ============================================================================
// morph_frame_sequencer
//
// Frame-level controller for a 3x3 morphology core (dilation/erosion) that is
// fed by a raster pixel stream.  It sits between the thresholding stage and
// the morphology core.  On start it latches the frame size and clears the
// core's line buffers.  It then forwards the input pixels and finally flushes
// the core with pad pixels, so that exactly width*height results leave per
// frame.  busy/done/err are reported to the host.
//
// Parameters
//   N            pixel width in bits (matches the core)
//   FLUSH_PIXEL  value injected into the core while flushing
//   FLUSH_SLACK  flush cycles allowed beyond 2*width before giving up
//
// Ports
//   clock, reset        single clock, synchronous active-high reset
//   start               begin a frame (only looked at while idle)
//   width, height       frame size, latched on an accepted start
//   busy                high from the cycle after start until done
//   done                one-cycle pulse at frame end
//   err                 sticky: dropped input or flush timeout
//   in_write, in_pixel  input pixel stream
//   core_clear          core line-buffer clear (core reset_n = ~core_clear)
//   core_width          latched width for the core
//   core_write/pixel    pixel stream into the core
//   core_valid/out_pixel result stream from the core
//   out_write/pixel     result stream to the next stage
//
// Build option
//   MORPH_SEQ_BORDER_CLEAR_EN
//     When defined, the output x/y position is tracked and results on the
//     outermost frame ring are forced to zero, hiding the edge artefacts of
//     the 3x3 window.  Strobe timing is identical in both builds.
// ============================================================================

module morph_frame_sequencer #(
   parameter int             N           = 1,
   parameter logic [N-1:0]   FLUSH_PIXEL = '0,
   parameter int             FLUSH_SLACK = 8
) (
   input  logic          clock,
   input  logic          reset,

   input  logic          start,
   input  logic [15:0]   width,
   input  logic [15:0]   height,
   output logic          busy,
   output logic          done,
   output logic          err,

   input  logic          in_write,
   input  logic [N-1:0]  in_pixel,

   output logic          core_clear,
   output logic [15:0]   core_width,
   output logic          core_write,
   output logic [N-1:0]  core_pixel,
   input  logic          core_valid,
   input  logic [N-1:0]  core_out_pixel,

   output logic          out_write,
   output logic [N-1:0]  out_pixel
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_RUN,
      ST_FLUSH,
      ST_DONE
   } state_t;

   state_t        state;
   logic [15:0]   width_q;
   logic [31:0]   total_q;
   logic [31:0]   in_cnt;
   logic [31:0]   out_cnt;
   logic [17:0]   flush_cnt;
   logic          core_clear_q;

   logic          active;
   logic          emit;
   logic          last_in;
   logic          out_finished;
   logic          timeout;
   logic [31:0]   in_cnt_inc;
   logic [31:0]   out_cnt_inc;
   logic [17:0]   flush_cnt_inc;
   logic [17:0]   flush_limit;
   logic [N-1:0]  result_pixel;

   // Results are only accepted while the core is being fed (RUN or FLUSH),
   // and anything the core produces beyond the frame size is discarded.
   assign active      = (state == ST_RUN) || (state == ST_FLUSH);
   assign in_cnt_inc  = in_cnt + 32'd1;
   assign out_cnt_inc = out_cnt + 32'd1;
   assign emit        = active && core_valid && (out_cnt < total_q);

   // The frame's output side is complete either because it already was, or
   // because the result being emitted this cycle is the last one.  This is
   // checked ahead of the flush timeout so a late last result still wins.
   assign out_finished = (out_cnt == total_q) || (emit && (out_cnt_inc == total_q));

   // The input strobe that brings the input count up to the frame size.
   assign last_in = (state == ST_RUN) && in_write && (in_cnt_inc == total_q);

   // A 3x3 window needs roughly two lines of padding to drain; give it that
   // plus some slack before declaring the core stuck.
   assign flush_limit   = {1'b0, width_q, 1'b0} + 18'(FLUSH_SLACK);
   assign flush_cnt_inc = flush_cnt + 18'd1;
   assign timeout       = (flush_cnt_inc >= flush_limit);

   // The core must stay cleared for as long as reset is held, independent
   // of the clock, so reset is folded straight into the clear output.
   assign core_clear = reset | core_clear_q;
   assign core_width = width_q;

`ifdef MORPH_SEQ_BORDER_CLEAR_EN
   logic [15:0]   height_q;
   logic [15:0]   x_cnt;
   logic [15:0]   y_cnt;
   logic          on_border;

   // The 3x3 window reads padding on the outermost ring of the frame, so
   // those results are meaningless and get replaced by zero.
   assign on_border = (x_cnt == 16'd0) || (x_cnt == width_q - 16'd1) ||
                      (y_cnt == 16'd0) || (y_cnt == height_q - 16'd1);
   assign result_pixel = on_border ? '0 : core_out_pixel;

   // Raster position of the next result to be emitted.  It restarts on every
   // accepted start and advances only on results that are actually emitted.
   always_ff @(posedge clock) begin
      if (reset) begin
         height_q <= 16'd0;
         x_cnt    <= 16'd0;
         y_cnt    <= 16'd0;
      end else if ((state == ST_IDLE) && start) begin
         height_q <= height;
         x_cnt    <= 16'd0;
         y_cnt    <= 16'd0;
      end else if (emit) begin
         if (x_cnt == width_q - 16'd1) begin
            x_cnt <= 16'd0;
            y_cnt <= y_cnt + 16'd1;
         end else begin
            x_cnt <= x_cnt + 16'd1;
         end
      end
   end
`else
   assign result_pixel = core_out_pixel;
`endif

   // Frame sequencing FSM with all host- and core-facing outputs registered.
   // Pulsed outputs default low every cycle and are raised only by the state
   // that owns them.  Any input strobe that cannot be forwarded in the current
   // state is dropped and flagged in err, which stays set until the next
   // accepted start.  A zero-sized frame skips the core entirely and only
   // produces a done pulse.
   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= ST_IDLE;
         width_q      <= 16'd0;
         total_q      <= 32'd0;
         in_cnt       <= 32'd0;
         out_cnt      <= 32'd0;
         flush_cnt    <= 18'd0;
         core_clear_q <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
         core_write   <= 1'b0;
         core_pixel   <= '0;
         out_write    <= 1'b0;
         out_pixel    <= '0;
      end else begin
         done         <= 1'b0;
         core_clear_q <= 1'b0;
         core_write   <= 1'b0;
         core_pixel   <= '0;
         out_write    <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (start) begin
                  width_q   <= width;
                  total_q   <= {16'd0, width} * {16'd0, height};
                  in_cnt    <= 32'd0;
                  out_cnt   <= 32'd0;
                  flush_cnt <= 18'd0;
                  err       <= 1'b0;
                  busy      <= 1'b1;
                  if ((width == 16'd0) || (height == 16'd0)) begin
                     state <= ST_DONE;
                  end else begin
                     core_clear_q <= 1'b1;
                     state        <= ST_CLEAR;
                  end
               end else if (in_write) begin
                  err <= 1'b1;
               end
            end

            ST_CLEAR: begin
               if (in_write) begin
                  err <= 1'b1;
               end
               state <= ST_RUN;
            end

            ST_RUN: begin
               core_write <= in_write;
               core_pixel <= in_pixel;
               if (in_write) begin
                  in_cnt <= in_cnt_inc;
               end
               // If the core already delivered every result, no flush is
               // needed once the last input has been handed over.
               if (last_in) begin
                  state <= out_finished ? ST_DONE : ST_FLUSH;
               end
            end

            ST_FLUSH: begin
               core_write <= 1'b1;
               core_pixel <= FLUSH_PIXEL;
               flush_cnt  <= flush_cnt_inc;
               if (in_write) begin
                  err <= 1'b1;
               end
               if (out_finished) begin
                  state <= ST_DONE;
               end else if (timeout) begin
                  err   <= 1'b1;
                  state <= ST_DONE;
               end
            end

            ST_DONE: begin
               if (in_write) begin
                  err <= 1'b1;
               end
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase

         // Result path: one cycle behind the core, clipped to the frame size.
         if (active) begin
            out_write <= emit;
            out_pixel <= result_pixel;
            if (emit) begin
               out_cnt <= out_cnt_inc;
            end
         end else begin
            out_pixel <= '0;
         end
      end
   end

endmodule

// File: tb/tb_morph_frame_sequencer.sv
// ============================================================================
// tb_morph_frame_sequencer
//
// Self-checking bench for morph_frame_sequencer.  A behavioural core (a plain
// delay line holding the last core_lag written pixels) answers the
// sequencer, so every result equals the input pixel at the same raster index,
// zeroed on the frame border when MORPH_SEQ_BORDER_CLEAR_EN is defined.
// ============================================================================

module tb_morph_frame_sequencer;

   localparam int            N           = 4;
   localparam logic [N-1:0]  PAD         = 4'h5;
   localparam int            SLACK       = 8;
   localparam int            DONE_BUDGET = 400;

   logic          clock = 1'b0;
   logic          reset;
   logic          start;
   logic [15:0]   width;
   logic [15:0]   height;
   logic          busy;
   logic          done;
   logic          err;
   logic          in_write;
   logic [N-1:0]  in_pixel;
   logic          core_clear;
   logic [15:0]   core_width;
   logic          core_write;
   logic [N-1:0]  core_pixel;
   logic          core_valid;
   logic [N-1:0]  core_out_pixel;
   logic          out_write;
   logic [N-1:0]  out_pixel;

   always #5 clock = ~clock;

   morph_frame_sequencer #(
      .N           (N),
      .FLUSH_PIXEL (PAD),
      .FLUSH_SLACK (SLACK)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .start          (start),
      .width          (width),
      .height         (height),
      .busy           (busy),
      .done           (done),
      .err            (err),
      .in_write       (in_write),
      .in_pixel       (in_pixel),
      .core_clear     (core_clear),
      .core_width     (core_width),
      .core_write     (core_write),
      .core_pixel     (core_pixel),
      .core_valid     (core_valid),
      .core_out_pixel (core_out_pixel),
      .out_write      (out_write),
      .out_pixel      (out_pixel)
   );

   int            checks   = 0;
   int            passes   = 0;
   int            fails    = 0;
   int            core_lag = 1000;
   int            done_cnt = 0;
   logic [N-1:0]  core_fifo[$];
   logic [N-1:0]  core_seen_q[$];
   logic [N-1:0]  got_q[$];
   logic [N-1:0]  in_q[$];

   // Behavioural core plus output monitor.  Everything is sampled on the
   // falling edge, and core_valid is driven there for the next rising edge.
   initial begin
      core_valid     = 1'b0;
      core_out_pixel = '0;
      forever begin
         @(negedge clock);
         if (core_clear) begin
            core_fifo.delete();
         end else if (core_write) begin
            core_fifo.push_back(core_pixel);
            core_seen_q.push_back(core_pixel);
         end
         if (out_write) got_q.push_back(out_pixel);
         if (done) done_cnt++;
         if (!core_clear && (core_fifo.size() > core_lag)) begin
            core_valid     = 1'b1;
            core_out_pixel = core_fifo.pop_front();
         end else begin
            core_valid     = 1'b0;
            core_out_pixel = N'($urandom);
         end
      end
   end

   // Expected result for raster index i of a w x h frame.
   function automatic logic [N-1:0] expect_pixel(input logic [N-1:0] v, input int i,
                                                 input int w, input int h);
`ifdef MORPH_SEQ_BORDER_CLEAR_EN
      int x;
      int y;
      x = i % w;
      y = i / w;
      if ((x == 0) || (x == w - 1) || (y == 0) || (y == h - 1)) return '0;
`endif
      return v;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic beginFrame(input int w, input int h, input int lag);
      @(negedge clock);
      core_lag = lag;
      width    = 16'(w);
      height   = 16'(h);
      start    = 1'b1;
      got_q.delete();
      core_seen_q.delete();
      in_q.delete();
      done_cnt = 0;
      @(negedge clock);
      start = 1'b0;
   endtask

   // Streams 'total' pixels with random gaps; fixed >= 0 gives a constant
   // pixel value.  'extra' adds one more strobe right after the last pixel.
   task automatic applyStimulus(input int total, input int gap_pct, input int fixed, input bit extra);
      int sent;
      sent = 0;
      while (sent < total) begin
         @(negedge clock);
         if ((gap_pct > 0) && (int'($urandom_range(99, 0)) < gap_pct)) begin
            in_write = 1'b0;
            in_pixel = N'($urandom);
         end else begin
            in_write = 1'b1;
            in_pixel = (fixed >= 0) ? N'(fixed) : N'($urandom);
            in_q.push_back(in_pixel);
            sent++;
         end
      end
      @(negedge clock);
      in_write = extra;
      in_pixel = N'($urandom);
      if (extra) begin
         @(negedge clock);
         in_write = 1'b0;
      end
   endtask

   task automatic waitDone(input string tag);
      int n;
      bit seen;
      n    = 0;
      seen = 1'b0;
      while ((n < DONE_BUDGET) && !seen) begin
         @(negedge clock);
         if (done) seen = 1'b1;
         n++;
      end
      checkOutput($sformatf("%s/done_seen", tag), 32'(seen), 32'd1);
      repeat (2) @(negedge clock);
   endtask

   // exp_pads < 0 means the pad count is not pinned down for this frame.
   task automatic checkFrame(input string tag, input int w, input int h, input bit exp_err,
                             input int exp_pads, input bit expect_out);
      int total;
      total = w * h;
      waitDone(tag);
      checkOutput($sformatf("%s/done_pulses", tag), 32'(done_cnt), 32'd1);
      checkOutput($sformatf("%s/busy_after", tag), 32'(busy), 32'd0);
      checkOutput($sformatf("%s/err", tag), 32'(err), 32'(exp_err));
      if (expect_out) begin
         checkOutput($sformatf("%s/out_count", tag), 32'(got_q.size()), 32'(total));
         for (int i = 0; (i < got_q.size()) && (i < in_q.size()); i++)
            checkOutput($sformatf("%s/out_pixel[%0d]", tag, i), 32'(got_q[i]),
                        32'(expect_pixel(in_q[i], i, w, h)));
      end else begin
         checkOutput($sformatf("%s/out_count", tag), 32'(got_q.size()), 32'd0);
      end
      for (int i = 0; i < core_seen_q.size(); i++)
         checkOutput($sformatf("%s/core_pixel[%0d]", tag, i), 32'(core_seen_q[i]),
                     32'((i < in_q.size()) ? in_q[i] : PAD));
      if (exp_pads >= 0)
         checkOutput($sformatf("%s/core_writes", tag), 32'(core_seen_q.size()), 32'(total + exp_pads));
      else
         checkOutput($sformatf("%s/core_writes_min", tag), 32'(core_seen_q.size() >= total), 32'd1);
   endtask

   initial begin
      int ones;
      int w;
      int h;
      int lag;
      int gap;

      reset    = 1'b1;
      start    = 1'b0;
      width    = 16'd0;
      height   = 16'd0;
      in_write = 1'b0;
      in_pixel = '0;

      $display("[TB] reset");
      repeat (3) begin
         @(negedge clock);
         checkOutput("reset/core_clear", 32'(core_clear), 32'd1);
      end
      checkOutput("reset/busy", 32'(busy), 32'd0);
      checkOutput("reset/done", 32'(done), 32'd0);
      checkOutput("reset/err", 32'(err), 32'd0);
      checkOutput("reset/out_write", 32'(out_write), 32'd0);
      reset = 1'b0;
      @(negedge clock);
      checkOutput("reset/core_clear_released", 32'(core_clear), 32'd0);

      $display("[TB] 4x3 frame, back-to-back input");
      beginFrame(4, 3, 5);
      checkOutput("f4x3/busy", 32'(busy), 32'd1);
      checkOutput("f4x3/core_width", 32'(core_width), 32'd4);
      applyStimulus(12, 0, -1, 1'b0);
      checkFrame("f4x3", 4, 3, 1'b0, -1, 1'b1);

      $display("[TB] zero-width frame");
      @(negedge clock);
      width  = 16'd0;
      height = 16'd3;
      start  = 1'b1;
      got_q.delete();
      done_cnt = 0;
      @(negedge clock);
      start = 1'b0;
      checkOutput("w0/busy", 32'(busy), 32'd1);
      checkOutput("w0/done_early", 32'(done), 32'd0);
      @(negedge clock);
      checkOutput("w0/done", 32'(done), 32'd1);
      checkOutput("w0/busy_low", 32'(busy), 32'd0);
      @(negedge clock);
      checkOutput("w0/done_single", 32'(done), 32'd0);
      repeat (3) @(negedge clock);
      checkOutput("w0/out_count", 32'(got_q.size()), 32'd0);
      checkOutput("w0/done_pulses", 32'(done_cnt), 32'd1);

      $display("[TB] dropped input in IDLE and FLUSH");
      @(negedge clock);
      in_write = 1'b1;
      in_pixel = 4'h3;
      @(negedge clock);
      in_write = 1'b0;
      @(negedge clock);
      checkOutput("idle_drop/err", 32'(err), 32'd1);
      beginFrame(3, 2, 2);
      checkOutput("idle_drop/err_cleared", 32'(err), 32'd0);
      applyStimulus(6, 0, -1, 1'b1);
      checkFrame("flush_drop", 3, 2, 1'b1, -1, 1'b1);

      $display("[TB] flush timeout");
      beginFrame(4, 3, 1000);
      applyStimulus(12, 0, -1, 1'b0);
      checkFrame("timeout", 4, 3, 1'b1, 2 * 4 + SLACK, 1'b0);

      $display("[TB] reset mid-frame");
      beginFrame(4, 4, 3);
      repeat (5) begin
         @(negedge clock);
         in_write = 1'b1;
         in_pixel = N'($urandom);
      end
      @(negedge clock);
      in_write = 1'b0;
      reset    = 1'b1;
      @(negedge clock);
      checkOutput("midreset/busy", 32'(busy), 32'd0);
      checkOutput("midreset/core_clear", 32'(core_clear), 32'd1);
      checkOutput("midreset/out_write", 32'(out_write), 32'd0);
      reset = 1'b0;
      repeat (10) @(negedge clock);
      checkOutput("midreset/no_done", 32'(done_cnt), 32'd0);
      checkOutput("midreset/busy_idle", 32'(busy), 32'd0);
      checkOutput("midreset/err", 32'(err), 32'd0);

      $display("[TB] 5x5 all-ones frame");
      beginFrame(5, 5, 6);
      applyStimulus(25, 0, (1 << N) - 1, 1'b0);
      checkFrame("ones5x5", 5, 5, 1'b0, -1, 1'b1);
      ones = 0;
      foreach (got_q[i]) if (got_q[i] == N'((1 << N) - 1)) ones++;
`ifdef MORPH_SEQ_BORDER_CLEAR_EN
      checkOutput("ones5x5/ones", 32'(ones), 32'd9);
`else
      checkOutput("ones5x5/ones", 32'(ones), 32'd25);
`endif

      $display("[TB] random frames");
      for (int f = 0; f < 6; f++) begin
         w   = int'($urandom_range(6, 1));
         h   = int'($urandom_range(5, 1));
         lag = int'($urandom_range(w + 1, 0));
         gap = int'($urandom_range(50, 0));
         beginFrame(w, h, lag);
         applyStimulus(w * h, gap, -1, 1'b0);
         checkFrame($sformatf("rand%0d_%0dx%0d", f, w, h), w, h, 1'b0, -1, 1'b1);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
